// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator control unit: FSM states, opcodes, ALU and mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_F    = 4'd0,
        ST_D    = 4'd1,
        ST_OP1  = 4'd2,
        ST_OP2  = 4'd3,
        ST_WC   = 4'd4,
        ST_GA   = 4'd5,
        ST_WB   = 4'd6,
        ST_OA   = 4'd7,
        ST_BR   = 4'd8,
        ST_COU  = 4'd9,
        ST_HALT = 4'd10
    } state_t;

    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_RES = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] MUX_NONE = 2'b00;
    localparam logic [1:0] MUX_OP1  = 2'b01;
    localparam logic [1:0] MUX_OP2  = 2'b10;
    localparam logic [1:0] MUX_WR   = 2'b11;

    function automatic logic [1:0] alu_sel(input logic [2:0] op);
        case (op)
            OP_RES:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode of the control FSM; combinational, zero latency.
// Only enir (mem_ready) and ldpc (zero) see inputs other than state/op_q.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 3
) (
    input  state_t         state,
    input  logic [OPW-1:0] op_q,
    input  logic           mem_ready,
    input  logic           zero,
    input  logic           illegal_q,
    output logic           enmem,
    output logic           enir,
    output logic           enrop1,
    output logic           enrop2,
    output logic           enrio,
    output logic           enpc,
    output logic           ldpc,
    output logic [1:0]     seloper,
    output logic [1:0]     selmux,
    output logic           halted,
    output logic           illegal
);

    logic [1:0] alu_op;

    // An illegal op never reaches OP2/WC; the qualifier keeps the ALU select at add regardless.
    assign alu_op = (|(op_q >> 3)) ? ALU_ADD : alu_sel(op_q[2:0]);

    always_comb begin
        enmem   = 1'b0;
        enir    = 1'b0;
        enrop1  = 1'b0;
        enrop2  = 1'b0;
        enrio   = 1'b0;
        enpc    = 1'b0;
        ldpc    = 1'b0;
        seloper = ALU_ADD;
        selmux  = MUX_NONE;
        halted  = 1'b0;
        illegal = 1'b0;
        case (state)
            ST_F:    enir = mem_ready;
            ST_OP1:  begin enrop1 = 1'b1; selmux = MUX_OP1; end
            ST_OP2:  begin enrop2 = 1'b1; selmux = MUX_OP2; seloper = alu_op; end
            ST_WC:   begin enmem  = 1'b1; selmux = MUX_WR;  seloper = alu_op; end
            ST_GA:   begin enrop1 = 1'b1; selmux = MUX_OP1; end
            ST_WB:   begin enmem  = 1'b1; selmux = MUX_OP2; end
            ST_OA:   begin enrio  = 1'b1; selmux = MUX_OP1; end
            ST_BR:   ldpc = zero;
            ST_COU:  begin enpc = 1'b1; illegal = illegal_q; end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_unit_v2.sv
// Multi-cycle accumulator controller: state register, latched opcode and illegal flag, next-state logic.
// Instructions take 3-6 cycles plus one per mem_ready-low cycle in F/WC/WB; outputs forced low during reset.
module ctrl_unit_v2
    import ctrl_pkg::*;
#(
    parameter int OPW    = 3,
    parameter bit MEM_HS = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           enmem,
    output logic           enir,
    output logic           enrop1,
    output logic           enrop2,
    output logic           enrio,
    output logic           enpc,
    output logic           ldpc,
    output logic [1:0]     seloper,
    output logic [1:0]     selmux,
    output logic           halted,
    output logic           illegal
);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic           illegal_q;
    logic           mem_ok;
    logic           op_bad;

    logic       d_enmem, d_enir, d_enrop1, d_enrop2, d_enrio, d_enpc, d_ldpc;
    logic       d_halted, d_illegal;
    logic [1:0] d_seloper, d_selmux;

    assign mem_ok = MEM_HS ? mem_ready : 1'b1;
    assign op_bad = |(opcode >> 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_F;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_F:   if (mem_ok) state <= ST_D;
                ST_D: begin
                    op_q <= opcode;
                    if (op_bad) begin
                        state     <= ST_COU;
                        illegal_q <= 1'b1;
                    end else begin
                        case (opcode[2:0])
                            OP_MOV:  state <= ST_GA;
                            OP_OUT:  state <= ST_OA;
                            OP_JZ:   state <= ST_BR;
                            OP_HLT:  state <= ST_HALT;
                            default: state <= ST_OP1;
                        endcase
                    end
                end
                ST_OP1: state <= ST_OP2;
                ST_OP2: state <= ST_WC;
                ST_WC:  if (mem_ok) state <= ST_COU;
                ST_GA:  state <= ST_WB;
                ST_WB:  if (mem_ok) state <= ST_COU;
                ST_OA:  state <= ST_COU;
                ST_BR:  state <= zero ? ST_F : ST_COU;
                ST_COU: begin
                    state     <= ST_F;
                    illegal_q <= 1'b0;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_F;
            endcase
        end
    end

    ctrl_decode #(.OPW(OPW)) u_decode (
        .state     (state),
        .op_q      (op_q),
        .mem_ready (mem_ok),
        .zero      (zero),
        .illegal_q (illegal_q),
        .enmem     (d_enmem),
        .enir      (d_enir),
        .enrop1    (d_enrop1),
        .enrop2    (d_enrop2),
        .enrio     (d_enrio),
        .enpc      (d_enpc),
        .ldpc      (d_ldpc),
        .seloper   (d_seloper),
        .selmux    (d_selmux),
        .halted    (d_halted),
        .illegal   (d_illegal)
    );

    // State already sits in F during reset, so enir must be masked explicitly.
    assign enmem   = rst_n & d_enmem;
    assign enir    = rst_n & d_enir;
    assign enrop1  = rst_n & d_enrop1;
    assign enrop2  = rst_n & d_enrop2;
    assign enrio   = rst_n & d_enrio;
    assign enpc    = rst_n & d_enpc;
    assign ldpc    = rst_n & d_ldpc;
    assign halted  = rst_n & d_halted;
    assign illegal = rst_n & d_illegal;
    assign seloper = rst_n ? d_seloper : 2'b00;
    assign selmux  = rst_n ? d_selmux  : 2'b00;

endmodule

// File: tb/tb_ctrl_unit_v2.sv
// Scoreboard bench: per-instruction cycle sequences are generated from the opcode rules and compared each cycle.
module tb_ctrl_unit_v2;

    typedef struct packed {
        logic       enmem;
        logic       enir;
        logic       enrop1;
        logic       enrop2;
        logic       enrio;
        logic       enpc;
        logic       ldpc;
        logic [1:0] seloper;
        logic [1:0] selmux;
        logic       halted;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic       mr;
        logic       z;
        logic [3:0] opc;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       enmem, enir, enrop1, enrop2, enrio, enpc, ldpc, halted, illegal;
    logic [1:0] seloper, selmux;
    out_t       act;

    stim_t stim_q[$];
    out_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    run = 1'b0;

    ctrl_unit_v2 #(.OPW(4), .MEM_HS(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .enmem     (enmem),
        .enir      (enir),
        .enrop1    (enrop1),
        .enrop2    (enrop2),
        .enrio     (enrio),
        .enpc      (enpc),
        .ldpc      (ldpc),
        .seloper   (seloper),
        .selmux    (selmux),
        .halted    (halted),
        .illegal   (illegal)
    );

    assign act = {enmem, enir, enrop1, enrop2, enrio, enpc, ldpc, seloper, selmux, halted, illegal};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic push(input logic mr, input logic z, input logic [3:0] opc, input out_t e);
        stim_t s;
        s.mr = mr; s.z = z; s.opc = opc;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, starting in fetch.
    task automatic gen_instr(input logic [3:0] op, input int sf, input int sw, input logic z);
        out_t e;
        logic [1:0] alu;
        for (int i = 0; i < sf; i++) begin
            e = '0; push(1'b0, rb(), rop(), e);
        end
        e = '0; e.enir = 1'b1; push(1'b1, rb(), rop(), e);
        e = '0; push(rb(), rb(), op, e);
        if (op[3]) begin
            e = '0; e.enpc = 1'b1; e.illegal = 1'b1; push(rb(), rb(), rop(), e);
            return;
        end
        case (op[2:0])
            3'b000: alu = 2'b00;
            3'b001: alu = 2'b01;
            3'b100: alu = 2'b10;
            default: alu = 2'b11;
        endcase
        case (op[2:0])
            3'b000, 3'b001, 3'b100, 3'b101: begin
                e = '0; e.enrop1 = 1'b1; e.selmux = 2'b01; push(rb(), rb(), rop(), e);
                e = '0; e.enrop2 = 1'b1; e.selmux = 2'b10; e.seloper = alu; push(rb(), rb(), rop(), e);
                e = '0; e.enmem = 1'b1; e.selmux = 2'b11; e.seloper = alu;
                for (int i = 0; i < sw; i++) push(1'b0, rb(), rop(), e);
                push(1'b1, rb(), rop(), e);
            end
            3'b010: begin
                e = '0; e.enrop1 = 1'b1; e.selmux = 2'b01; push(rb(), rb(), rop(), e);
                e = '0; e.enmem = 1'b1; e.selmux = 2'b10;
                for (int i = 0; i < sw; i++) push(1'b0, rb(), rop(), e);
                push(1'b1, rb(), rop(), e);
            end
            3'b011: begin
                e = '0; e.enrio = 1'b1; e.selmux = 2'b01; push(rb(), rb(), rop(), e);
            end
            3'b110: begin
                e = '0; e.ldpc = z; push(rb(), z, rop(), e);
                if (z) return;
            end
            default: begin
                e = '0; e.halted = 1'b1;
                for (int i = 0; i < 20; i++) push(rb(), rb(), rop(), e);
                return;
            end
        endcase
        e = '0; e.enpc = 1'b1; push(rb(), rb(), rop(), e);
    endtask

    task automatic chk(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
        end
    endtask

    task automatic run_seg();
        stim_t s;
        @(negedge clk);
        rst_n = 1'b1;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            mem_ready = s.mr;
            zero      = s.z;
            opcode    = s.opc;
            run       = 1'b1;
            @(negedge clk);
        end
        #3;
        run = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1 chk({nm, "_async"}, act, '0);
        @(posedge clk);
        #1 chk({nm, "_held"}, act, '0);
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            #2;
            if (run && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out", act, e);
            end
        end
    end

    initial begin : main
        out_t e1;
        repeat (3) @(posedge clk);
        #1 chk("rst_init", act, '0);

        gen_instr(4'b0000, 0, 0, 1'b0);
        gen_instr(4'b0100, 3, 2, 1'b0);
        gen_instr(4'b0110, 0, 0, 1'b1);
        gen_instr(4'b0110, 0, 0, 1'b0);
        gen_instr(4'b1010, 0, 0, 1'b0);
        gen_instr(4'b0010, 1, 1, 1'b0);
        gen_instr(4'b0011, 2, 0, 1'b0);
        gen_instr(4'b0111, 0, 0, 1'b0);
        run_seg();
        do_reset("rst_halt1");

        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            op = rop();
            if (op == 4'b0111) op = 4'b0101;
            gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end
        gen_instr(4'b0111, 1, 0, 1'b0);
        run_seg();
        do_reset("rst_halt2");

        // SUM left stalled in WC, then reset lands between clock edges.
        e1 = '0; e1.enir = 1'b1; push(1'b1, 1'b0, 4'b0101, e1);
        e1 = '0; push(1'b1, 1'b0, 4'b0000, e1);
        e1 = '0; e1.enrop1 = 1'b1; e1.selmux = 2'b01; push(1'b1, 1'b0, 4'b1111, e1);
        e1 = '0; e1.enrop2 = 1'b1; e1.selmux = 2'b10; push(1'b1, 1'b0, 4'b1111, e1);
        e1 = '0; e1.enmem = 1'b1; e1.selmux = 2'b11;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 4'b0001, e1);
        run_seg();
        chk("wc_pre_reset", act, e1);
        rst_n = 1'b0;
        #1 chk("rst_mid_wc", act, '0);
        @(posedge clk);
        #1 chk("rst_mid_wc_held", act, '0);

        gen_instr(4'b0011, 0, 0, 1'b0);
        gen_instr(4'b0001, 0, 1, 1'b0);
        run_seg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_unit_v2.md
# ctrl_unit_v2

Parametrised multi-cycle control unit for the accumulator datapath, replacing the fixed 4-operation controller. It sequences fetch, decode, operand load, ALU write-back, I/O output and PC increment. Compared with the previous controller it adds:
- a memory handshake;
- an opcode register latched at decode;
- logical ops, a conditional branch and halt;
- illegal-opcode trapping.

It sits between the instruction register opcode field, the memory interface and the datapath enables/selects.

## Interface
Parameters:
- OPW, 3, opcode width; must be ≥3; bits above [2:0] non-zero = illegal opcode.
- MEM_HS, 1, 1 = fetch/write states wait for mem_ready; 0 = mem_ready treated as constant 1.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  opcode field from instruction register, sampled only in D.
- zero  in  1  ALU zero flag, sampled only in BR.
- mem_ready  in  1  memory access complete this cycle.
- enmem  out  1  memory write enable.
- enir  out  1  instruction register load.
- enrop1  out  1  operand-1 register load.
- enrop2  out  1  operand-2 register load.
- enrio  out  1  output-port register load.
- enpc  out  1  PC increment.
- ldpc  out  1  PC parallel load (branch taken).
- seloper  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
- selmux  out  2  datapath mux select.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse in COU after an illegal opcode.

## Operation
- Opcodes [2:0]: 000 SUM, 001 RES, 010 MOV, 011 OUT, 100 AND, 101 OR, 110 JZ, 111 HLT.
- op_q (OPW bits) is loaded from opcode on the D cycle only. All later outputs use op_q, never the live opcode.
- States: F, D, OP1, OP2, WC, GA, WB, OA, BR, COU, HALT.
- Transitions:
  - F→D when mem_ready, else stay in F.
  - D→OP1 for SUM/RES/AND/OR; D→GA for MOV; D→OA for OUT; D→BR for JZ; D→HALT for HLT.
  - D→COU for an illegal opcode; illegal_q is set.
  - OP1→OP2→WC; WC→COU when mem_ready, else stay in WC.
  - GA→WB; WB→COU when mem_ready, else stay in WB.
  - OA→COU.
  - BR→F if zero (branch taken), else BR→COU.
  - COU→F.
  - HALT→HALT until reset.
  - Unused encodings→F.
- Outputs by state (any signal not listed is 0):
  - F: enir = mem_ready.
  - D: none.
  - OP1: enrop1, selmux=01.
  - OP2: enrop2, selmux=10, seloper=alu(op_q).
  - WC: enmem, selmux=11, seloper=alu(op_q).
  - GA: enrop1, selmux=01.
  - WB: enmem, selmux=10, seloper=00.
  - OA: enrio, selmux=01.
  - BR: ldpc = zero.
  - COU: enpc; illegal = illegal_q.
  - HALT: halted.
- alu() maps SUM→00, RES→01, AND→10, OR→11.
- illegal_q is cleared on leaving COU. An illegal opcode causes no enrop/enmem/enrio activity.

## Timing
- Outputs are Moore-decoded from state and op_q. enir and ldpc also depend combinationally on mem_ready and zero respectively.
- Minimum instruction lengths, counting from the first F cycle (mem_ready=1 throughout):
  - SUM/RES/AND/OR: 6 cycles.
  - MOV: 5.
  - OUT: 4.
  - JZ taken: 3 (no enpc).
  - JZ not taken: 4.
  - Illegal: 3.
- Each mem_ready-low cycle in F, WC or WB adds exactly one cycle. enmem stays asserted throughout a WC/WB wait.
- Reset asserted (any time, including mid-instruction or in HALT):
  - state=F, op_q=0, illegal_q=0.
  - All outputs are 0 while rst_n=0; enir is forced 0 even if mem_ready=1.
- First enir is possible on the first rising edge after rst_n deasserts with mem_ready=1.
- mem_ready is ignored outside F/WC/WB. zero is ignored outside BR. A change on opcode after D has no effect.

## Structure
- Package ctrl_pkg holds:
  - state encodings (4-bit localparams F=0 … HALT=10);
  - opcode constants;
  - ALU seloper codes;
  - selmux codes.
- One sub-module, ctrl_decode: purely combinational (state, op_q, mem_ready, zero, illegal_q) → all outputs.
- The top level holds the state register, op_q, illegal_q and the next-state logic.

## Test plan
- Reset, then SUM (000) with mem_ready=1: enir@c0, D@c1, enrop1+selmux=01@c2, enrop2+seloper=00@c3, enmem+selmux=11@c4, enpc@c5, F@c6.
- AND (100) with mem_ready low for 3 cycles in F and 2 cycles in WC:
  - 11 cycles total;
  - enmem held high for 3 WC cycles;
  - seloper=10 in OP2 and WC;
  - opcode toggled to 011 after D → no change.
- JZ (110) with zero=1 → ldpc=1 in BR, next state F, no enpc. JZ with zero=0 → ldpc=0, enpc one cycle later.
- HLT (111) → halted=1 held for 20 cycles with no enables asserted; rst_n pulse → F, halted=0.
- OPW=4, opcode=1010 → D→COU, illegal=1 and enpc=1 in the same cycle, no enmem/enrop/enrio.
- rst_n asserted asynchronously mid-WC with mem_ready=0 → all outputs 0 before the next clock edge. After release, state F; op_q=0.
